// File: rtl/audio_pkg.sv
// -----------------------------------------------------------------------------
// audio_pkg
// Types and constants shared by the codec audio paths. The ADC capture path
// (i2s_adc_receiver) and the DAC serialiser both use these.
//   SAMPLE_WIDTH_DEFAULT : default channel word width in bits
//   i2s_rx_state_t       : capture FSM states (SYNC, LEFT, RIGHT)
//   sample_t             : one channel word at the default width
//   stereo_sample_t      : left/right pair of sample_t
// -----------------------------------------------------------------------------
package audio_pkg;

    localparam int SAMPLE_WIDTH_DEFAULT = 24;

    typedef enum logic [1:0] {
        SYNC  = 2'd0,   // waiting for a left-slot start; all captured bits discarded
        LEFT  = 2'd1,   // capturing the left word
        RIGHT = 2'd2    // capturing the right word
    } i2s_rx_state_t;

    typedef logic [SAMPLE_WIDTH_DEFAULT-1:0] sample_t;

    typedef struct packed {
        sample_t left;
        sample_t right;
    } stereo_sample_t;

endpackage

// File: rtl/i2s_adc_receiver_if.sv
// -----------------------------------------------------------------------------
// i2s_adc_receiver_if
// Downstream side of the ADC receiver: single-entry valid/ready holding
// register plus status.
//   sample_valid   receiver -> sink   held frame available
//   sample_ready   sink -> receiver   sink accepts the held frame
//   left_sample    receiver -> sink   held left word
//   right_sample   receiver -> sink   held right word
//   overrun        receiver -> sink   sticky; a completed frame was dropped
//   clear_overrun  sink -> receiver   clears overrun
//   short_word     receiver -> sink   one-clk pulse; a slot ended early
// The receiver connects through the master modport, the consumer through
// the slave modport.
// -----------------------------------------------------------------------------
interface i2s_adc_receiver_if #(
    parameter int SAMPLE_WIDTH = audio_pkg::SAMPLE_WIDTH_DEFAULT
) ();

    logic                    sample_valid;
    logic                    sample_ready;
    logic [SAMPLE_WIDTH-1:0] left_sample;
    logic [SAMPLE_WIDTH-1:0] right_sample;
    logic                    overrun;
    logic                    clear_overrun;
    logic                    short_word;

    modport master (
        output sample_valid,
        output left_sample,
        output right_sample,
        output overrun,
        output short_word,
        input  sample_ready,
        input  clear_overrun
    );

    modport slave (
        input  sample_valid,
        input  left_sample,
        input  right_sample,
        input  overrun,
        input  short_word,
        output sample_ready,
        output clear_overrun
    );

endinterface

// File: rtl/sync_edge_detect.sv
// -----------------------------------------------------------------------------
// sync_edge_detect
// STAGES-flop synchroniser for an asynchronous level, followed by a rising
// edge detector on the synchronised value.
//   clk    in   system clock
//   reset  in   synchronous, active-high
//   d      in   asynchronous input
//   rise   out  one-clk pulse: synced d was 0 last clk and is 1 now
// The pulse is aligned with the clk in which the synced level first reads 1,
// so other inputs passed through an equally deep synchroniser present the
// values that were on the pins alongside that edge.
// -----------------------------------------------------------------------------
module sync_edge_detect #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // NOTE: clocked blocks use non-blocking (<=) so every flop samples the
    // values from before the edge; blocking here would collapse the chain.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign rise = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/i2s_adc_receiver.sv
// -----------------------------------------------------------------------------
// i2s_adc_receiver
// Capture path for the codec ADC stream. Oversamples BCLK/LRCK/ADCDAT in the
// clk domain (clk >= 4x BCLK), deserialises left/right words MSB first and
// hands complete left+right frames downstream through a single-entry
// valid/ready holding register with sticky overrun.
//   clk        in   system clock
//   reset      in   synchronous, active-high
//   enable     in   capture enable; low forces the FSM to SYNC
//   bclk_in    in   codec bit clock, asynchronous
//   lrck_in    in   codec ADC word select, asynchronous; 0 = left
//   adcdat_in  in   codec ADC serial data, asynchronous
//   rx         if   master side of i2s_adc_receiver_if (frame + status)
// Parameters:
//   SAMPLE_WIDTH  bits per delivered channel word
//   DATA_DELAY    BCLK rises between an LRCK change and the MSB (1 = I2S,
//                 0 = left-justified)
//   SYNC_STAGES   synchroniser depth on each serial input (>= 2)
// -----------------------------------------------------------------------------
module i2s_adc_receiver
    import audio_pkg::*;
#(
    parameter int SAMPLE_WIDTH = SAMPLE_WIDTH_DEFAULT,
    parameter int DATA_DELAY   = 1,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  bclk_in,
    input  logic                  lrck_in,
    input  logic                  adcdat_in,
    i2s_adc_receiver_if.master    rx
);

    // bit_idx counts 0..SAMPLE_WIDTH and saturates, so it needs one extra code.
    localparam int IDX_W = $clog2(SAMPLE_WIDTH + 1);
    localparam logic [IDX_W-1:0]        IDX_LAST = IDX_W'(SAMPLE_WIDTH - 1);
    localparam logic [IDX_W-1:0]        IDX_SAT  = IDX_W'(SAMPLE_WIDTH);
    localparam logic [SAMPLE_WIDTH-1:0] MSB_ONE  = SAMPLE_WIDTH'(1) << (SAMPLE_WIDTH - 1);

    // ---------------------------------------------------------------- inputs
    logic                   bit_tick;
    logic [SYNC_STAGES-1:0] lrck_sync;
    logic [SYNC_STAGES-1:0] dat_sync;
    logic                   lrck_s;
    logic                   dat_s;

    sync_edge_detect #(.STAGES(SYNC_STAGES)) u_bclk_sync (
        .clk   (clk),
        .reset (reset),
        .d     (bclk_in),
        .rise  (bit_tick)
    );

    // Same depth as the BCLK chain, so at bit_tick these hold the LRCK/DATA
    // levels that were present at the BCLK rising edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            lrck_sync <= '0;
            dat_sync  <= '0;
        end else begin
            lrck_sync <= {lrck_sync[SYNC_STAGES-2:0], lrck_in};
            dat_sync  <= {dat_sync[SYNC_STAGES-2:0], adcdat_in};
        end
    end

    assign lrck_s = lrck_sync[SYNC_STAGES-1];
    assign dat_s  = dat_sync[SYNC_STAGES-1];

    // ------------------------------------------------ effective word select
    logic ws_cur;   // ws_eff at the current bit_tick

    generate
        if (DATA_DELAY == 0) begin : g_ws_direct
            assign ws_cur = lrck_s;
        end else begin : g_ws_delay
            logic [DATA_DELAY-1:0] ws_sr;
            always_ff @(posedge clk) begin
                if (reset) begin
                    ws_sr <= '0;
                end else if (bit_tick) begin
                    ws_sr <= (ws_sr << 1) | DATA_DELAY'(lrck_s);
                end
            end
            assign ws_cur = ws_sr[DATA_DELAY-1];
        end
    endgenerate

    // ------------------------------------------------------- capture state
    i2s_rx_state_t           state;
    i2s_rx_state_t           nxt_state;
    logic                    ws_prev;
    logic [IDX_W-1:0]        bit_idx;
    logic [IDX_W-1:0]        idx_now;
    logic [SAMPLE_WIDTH-1:0] acc;
    logic [SAMPLE_WIDTH-1:0] acc_nxt;
    logic                    boundary;
    logic                    short_done;
    logic                    full_done;
    logic                    left_ok;       // left word done in this frame
    logic [SAMPLE_WIDTH-1:0] left_word;
    logic [SAMPLE_WIDTH-1:0] right_word;
    logic                    frame_done;    // one-clk: left+right pair ready

    // Decode of what the current bit_tick means; only acted on when bit_tick.
    // NOTE: every variable is given a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        boundary  = (ws_cur != ws_prev);
        idx_now   = bit_idx;
        acc_nxt   = acc;
        nxt_state = state;

        if (boundary) begin
            idx_now = '0;
        end else if (bit_idx != IDX_SAT) begin
            idx_now = bit_idx + 1'b1;
        end

        // Bits are placed by index rather than shifted, so a word closed
        // early already has its missing LSBs at zero.
        if (boundary) begin
            acc_nxt = dat_s ? MSB_ONE : '0;
        end else if (idx_now != IDX_SAT && dat_s) begin
            acc_nxt = acc | (MSB_ONE >> idx_now);
        end

        if (boundary) begin
            case (state)
                SYNC:    nxt_state = ws_cur ? SYNC : LEFT;
                LEFT:    nxt_state = RIGHT;
                RIGHT:   nxt_state = LEFT;
                default: nxt_state = SYNC;
            endcase
        end

        // Old word closed at a boundary before all its bits arrived.
        short_done = boundary && (state != SYNC) && (bit_idx < IDX_LAST);
        // Word in the slot this tick belongs to captured its final bit.
        full_done  = (nxt_state != SYNC) && (idx_now == IDX_LAST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= SYNC;
            ws_prev       <= 1'b0;
            bit_idx       <= '0;
            acc           <= '0;
            left_ok       <= 1'b0;
            left_word     <= '0;
            right_word    <= '0;
            frame_done    <= 1'b0;
            rx.short_word <= 1'b0;
        end else begin
            frame_done    <= 1'b0;
            rx.short_word <= 1'b0;

            // Slot tracking runs regardless of enable so that re-enabling
            // does not see a stale word select.
            if (bit_tick) begin
                ws_prev <= ws_cur;
                bit_idx <= idx_now;
                acc     <= acc_nxt;
            end

            if (!enable) begin
                state   <= SYNC;
                left_ok <= 1'b0;
            end else if (bit_tick) begin
                state <= nxt_state;

                if (short_done) begin
                    rx.short_word <= 1'b1;
                    if (state == LEFT) begin
                        left_word <= acc;
                        left_ok   <= 1'b1;
                    end else if (left_ok) begin
                        right_word <= acc;
                        frame_done <= 1'b1;
                        left_ok    <= 1'b0;
                    end
                end

                if (full_done) begin
                    if (nxt_state == LEFT) begin
                        left_word <= acc_nxt;
                        left_ok   <= 1'b1;
                    end else if (left_ok) begin
                        right_word <= acc_nxt;
                        frame_done <= 1'b1;
                        left_ok    <= 1'b0;
                    end
                end
            end
        end
    end

    // ---------------------------------------------------- holding register
    // left_word cannot change for at least SAMPLE_WIDTH bit periods after a
    // frame completes, so it is read directly in the load cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx.sample_valid <= 1'b0;
            rx.left_sample  <= '0;
            rx.right_sample <= '0;
            rx.overrun      <= 1'b0;
        end else begin
            if (frame_done && (!rx.sample_valid || rx.sample_ready)) begin
                rx.sample_valid <= 1'b1;
                rx.left_sample  <= left_word;
                rx.right_sample <= right_word;
            end else if (rx.sample_valid && rx.sample_ready) begin
                rx.sample_valid <= 1'b0;
            end

            // A drop in the same clk as clear_overrun leaves the flag set.
            if (frame_done && rx.sample_valid && !rx.sample_ready) begin
                rx.overrun <= 1'b1;
            end else if (rx.clear_overrun) begin
                rx.overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2s_adc_receiver.sv
// -----------------------------------------------------------------------------
// tb_i2s_adc_receiver
// Directed bench for i2s_adc_receiver. Two receivers share one serial stream:
// dut_i2s (DATA_DELAY=1) and dut_lj (DATA_DELAY=0). Delivered frames and
// short_word pulses are recorded at the falling clk edge and compared with
// hand-computed values.
// -----------------------------------------------------------------------------
module tb_i2s_adc_receiver;
    import audio_pkg::*;

    localparam int W = 24;

    logic clk = 1'b0;
    logic reset;
    logic enable;
    logic bclk;
    logic lrck;
    logic adcdat;

    always #5 clk = ~clk;

    i2s_adc_receiver_if #(.SAMPLE_WIDTH(W)) rx_a ();
    i2s_adc_receiver_if #(.SAMPLE_WIDTH(W)) rx_b ();

    i2s_adc_receiver #(.SAMPLE_WIDTH(W), .DATA_DELAY(1), .SYNC_STAGES(2)) dut_i2s (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .bclk_in   (bclk),
        .lrck_in   (lrck),
        .adcdat_in (adcdat),
        .rx        (rx_a)
    );

    i2s_adc_receiver #(.SAMPLE_WIDTH(W), .DATA_DELAY(0), .SYNC_STAGES(2)) dut_lj (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .bclk_in   (bclk),
        .lrck_in   (lrck),
        .adcdat_in (adcdat),
        .rx        (rx_b)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------- monitors
    stereo_sample_t q_a[$];
    stereo_sample_t q_b[$];
    int             short_a = 0;

    always @(negedge clk) begin
        stereo_sample_t e;
        if (rx_a.sample_valid && rx_a.sample_ready) begin
            e.left  = rx_a.left_sample;
            e.right = rx_a.right_sample;
            q_a.push_back(e);
        end
        if (rx_b.sample_valid && rx_b.sample_ready) begin
            e.left  = rx_b.left_sample;
            e.right = rx_b.right_sample;
            q_b.push_back(e);
        end
        if (rx_a.short_word) short_a++;
    end

    function automatic stereo_sample_t pick_a(input int i);
        return (i < q_a.size()) ? q_a[i] : '0;
    endfunction

    function automatic stereo_sample_t pick_b(input int i);
        return (i < q_b.size()) ? q_b[i] : '0;
    endfunction

    // ------------------------------------------------------ serial stimulus
    logic i2s_mode = 1'b1;   // data lags LRCK by one BCLK
    logic dly_bit  = 1'b0;   // bit owed to the next BCLK in I2S mode

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // One BCLK period (8 clks); LRCK/DATA change while BCLK is low.
    task automatic send_bit(input logic lr, input logic d);
        bclk   = 1'b0;
        lrck   = lr;
        adcdat = d;
        #40;
        bclk   = 1'b1;
        #40;
    endtask

    task automatic stream_bit(input logic lr, input logic b);
        if (i2s_mode) begin
            send_bit(lr, dly_bit);
            dly_bit = b;
        end else begin
            send_bit(lr, b);
        end
    endtask

    // Left-justified bit k of a slot carrying an nbits word, MSB first.
    function automatic logic lj_bit(input logic [31:0] word, input int nbits, input int k);
        return (k < nbits) ? word[nbits-1-k] : 1'b0;
    endfunction

    task automatic send_slot(input logic lr, input logic [31:0] word, input int nbits,
                             input int k0, input int k1);
        for (int k = k0; k < k1; k++) stream_bit(lr, lj_bit(word, nbits, k));
    endtask

    task automatic send_frame(input logic [31:0] l, input logic [31:0] r,
                              input int nbits, input int slot);
        send_slot(1'b0, l, nbits, 0, slot);
        send_slot(1'b1, r, nbits, 0, slot);
    endtask

    // ----------------------------------------------------------------- main
    initial begin
        stereo_sample_t f;

        reset  = 1'b1;
        enable = 1'b1;
        bclk   = 1'b0;
        lrck   = 1'b0;
        adcdat = 1'b0;
        rx_a.sample_ready  = 1'b1;
        rx_a.clear_overrun = 1'b0;
        rx_b.sample_ready  = 1'b1;
        rx_b.clear_overrun = 1'b0;
        wait_clks(4);

        check("rst_valid",   32'(rx_a.sample_valid), 32'h0);
        check("rst_left",    32'(rx_a.left_sample),  32'h0);
        check("rst_right",   32'(rx_a.right_sample), 32'h0);
        check("rst_overrun", 32'(rx_a.overrun),      32'h0);
        check("rst_short",   32'(rx_a.short_word),   32'h0);
        reset = 1'b0;
        wait_clks(2);

        // Stream starts mid right slot; first frame is the following pair.
        send_slot(1'b1, 32'hFFFFFF, W, 0, 10);
        send_frame(32'hABCDEF, 32'h123456, W, 32);
        wait_clks(20);
        f = pick_a(0);
        check("i2s_count",   32'(q_a.size()),   32'd1);
        check("i2s_left",    32'(f.left),       32'hABCDEF);
        check("i2s_right",   32'(f.right),      32'h123456);
        check("i2s_short",   32'(short_a),      32'd0);
        check("i2s_overrun", 32'(rx_a.overrun), 32'h0);

        // Sink stalled across three frames: first held, the rest dropped.
        q_a.delete();
        rx_a.sample_ready = 1'b0;
        send_frame(32'h000001, 32'h000002, W, 32);
        send_frame(32'h000003, 32'h000004, W, 32);
        send_frame(32'h000005, 32'h000006, W, 32);
        wait_clks(20);
        check("ovr_valid", 32'(rx_a.sample_valid), 32'h1);
        check("ovr_left",  32'(rx_a.left_sample),  32'h000001);
        check("ovr_right", 32'(rx_a.right_sample), 32'h000002);
        check("ovr_flag",  32'(rx_a.overrun),      32'h1);
        check("ovr_none",  32'(q_a.size()),        32'd0);
        rx_a.clear_overrun = 1'b1;
        rx_a.sample_ready  = 1'b1;
        wait_clks(1);
        rx_a.clear_overrun = 1'b0;
        wait_clks(4);
        f = pick_a(0);
        check("ovr_dlv_count", 32'(q_a.size()),        32'd1);
        check("ovr_dlv_left",  32'(f.left),            32'h000001);
        check("ovr_dlv_right", 32'(f.right),           32'h000002);
        check("ovr_dlv_valid", 32'(rx_a.sample_valid), 32'h0);
        check("ovr_cleared",   32'(rx_a.overrun),      32'h0);

        // Left-justified stream: dut_lj exact, dut_i2s one bit late.
        q_a.delete();
        q_b.delete();
        i2s_mode = 1'b0;
        send_frame(32'h800000, 32'h7FFFFF, W, 32);
        wait_clks(20);
        f = pick_b(0);
        check("lj_count", 32'(q_b.size()), 32'd1);
        check("lj_left",  32'(f.left),     32'h800000);
        check("lj_right", 32'(f.right),    32'h7FFFFF);
        f = pick_a(0);
        check("lj_dly_count", 32'(q_a.size()), 32'd1);
        check("lj_dly_left",  32'(f.left),     32'h000000);
        check("lj_dly_right", 32'(f.right),    32'hFFFFFE);

        // Enable dropped mid left slot while a frame is held.
        q_a.delete();
        i2s_mode = 1'b1;
        dly_bit  = 1'b0;
        rx_a.sample_ready = 1'b0;
        send_frame(32'h0A0A0A, 32'h0B0B0B, W, 32);
        send_slot(1'b0, 32'hFFFFFF, W, 0, 12);
        enable = 1'b0;
        send_slot(1'b0, 32'hFFFFFF, W, 12, 20);
        check("en_hold_valid", 32'(rx_a.sample_valid), 32'h1);
        check("en_hold_left",  32'(rx_a.left_sample),  32'h0A0A0A);
        check("en_hold_right", 32'(rx_a.right_sample), 32'h0B0B0B);
        enable = 1'b1;
        send_slot(1'b0, 32'hFFFFFF, W, 20, 32);
        send_slot(1'b1, 32'h333333, W, 0, 32);
        rx_a.sample_ready = 1'b1;
        send_frame(32'h456789, 32'h9ABCDE, W, 32);
        wait_clks(20);
        check("en_count", 32'(q_a.size()), 32'd2);
        f = pick_a(0);
        check("en_f0_left",  32'(f.left),  32'h0A0A0A);
        check("en_f0_right", 32'(f.right), 32'h0B0B0B);
        f = pick_a(1);
        check("en_f1_left",  32'(f.left),  32'h456789);
        check("en_f1_right", 32'(f.right), 32'h9ABCDE);
        check("en_overrun",  32'(rx_a.overrun), 32'h0);

        // 16-bit slots: words close early and are zero-filled.
        q_a.delete();
        short_a = 0;
        send_frame(32'hBEEF, 32'h1234, 16, 16);
        send_slot(1'b0, 32'h0, 16, 0, 2);
        wait_clks(20);
        f = pick_a(0);
        check("short_count", 32'(q_a.size()), 32'd1);
        check("short_left",  32'(f.left),     32'hBEEF00);
        check("short_right", 32'(f.right),    32'h123400);
        check("short_pulses", 32'(short_a),   32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
